// File: rtl/display_driver.sv
// -----------------------------------------------------------------------------
// display_driver
//   Output-display stage behind the sequencer. A `disp` strobe latches the
//   8-bit bus, a sequential shift-add-3 engine turns it into three BCD digits
//   over 8 cycles, and a scan engine drives a 4-digit common-anode display.
//   A one-deep pending buffer (latest strobe wins) ensures strobes are never
//   stalled.
//
//   Configuration macro: SIGNED_DISPLAY_EN
//     defined   : bus is two's complement, shown as -128..127 with a minus sign
//     undefined : bus is unsigned, shown as 0..255, sign digit always blank
//
// Ports
//   clk  in  1  system clock, rising edge
//   res  in  1  asynchronous active-low reset
//   disp in  1  display-load strobe, sampled with bus
//   bus  in  8  shared data bus
//   seg  out 7  segments {g,f,e,d,c,b,a}, active-low, registered
//   an   out 4  digit enables, active-low (0=ones 1=tens 2=hundreds 3=sign)
//   busy out 1  conversion in progress, registered
// -----------------------------------------------------------------------------
module display_driver #(
    parameter int REFRESH_DIV = 1024
) (
    input  logic       clk,
    input  logic       res,
    input  logic       disp,
    input  logic [7:0] bus,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       busy
);

    localparam int            CW      = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] REF_MAX = CW'(REFRESH_DIV - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [19:0]   shift_q, shift_d;
    logic [3:0]    iter_q, iter_d;
    logic          neg_next_q, neg_next_d;
    logic [7:0]    pend_val_q, pend_val_d;
    logic          pend_v_q, pend_v_d;
    logic [3:0]    dig_h_q, dig_h_d;
    logic [3:0]    dig_t_q, dig_t_d;
    logic [3:0]    dig_o_q, dig_o_d;
    logic          neg_q, neg_d;
    logic [CW-1:0] ref_cnt_q, ref_cnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          busy_q, busy_d;

    logic          start_s;
    logic [7:0]    start_val_s;
    logic          start_neg_s;
    logic [19:0]   adj_s;
    logic [19:0]   shifted_s;

    // Add 3 to a BCD nibble that is 5 or more so the following shift carries correctly.
    function automatic logic [3:0] nib_adj(input logic [3:0] n);
        if (n >= 4'd5) begin
            return n + 4'd3;
        end else begin
            return n;
        end
    endfunction

    // Apply the add-3 correction to all three BCD nibbles of the shift word.
    function automatic logic [19:0] add3(input logic [19:0] w);
        return {nib_adj(w[19:16]), nib_adj(w[15:12]), nib_adj(w[11:8]), w[7:0]};
    endfunction

    // Magnitude of the bus value as shown on the three numeric digits.
    function automatic logic [7:0] mag_of(input logic [7:0] v);
`ifdef SIGNED_DISPLAY_EN
        if (v[7]) begin
            return ~v + 8'd1;
        end else begin
            return v;
        end
`else
        return v;
`endif
    endfunction

    // Active-low seven-segment code {g..a} for a BCD digit.
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Conversion FSM, pending buffer and digit commit.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        iter_d      = iter_q;
        neg_next_d  = neg_next_q;
        pend_val_d  = pend_val_q;
        pend_v_d    = pend_v_q;
        dig_h_d     = dig_h_q;
        dig_t_d     = dig_t_q;
        dig_o_d     = dig_o_q;
        neg_d       = neg_q;
        start_s     = 1'b0;
        start_val_s = bus;
        adj_s       = add3(shift_q);
        shifted_s   = adj_s << 1'b1;

        case (state_q)
            IDLE: begin
                if (disp) begin
                    start_s     = 1'b1;
                    start_val_s = bus;
                end else begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                shift_d = shifted_s;
                iter_d  = iter_q + 4'd1;
                if (iter_q == 4'd7) begin
                    // Eighth shift completes the conversion: commit it.
                    dig_h_d = shifted_s[19:16];
                    dig_t_d = shifted_s[15:12];
                    dig_o_d = shifted_s[11:8];
                    neg_d   = neg_next_q;
                    // A strobe on this edge is newer than anything pending.
                    if (disp) begin
                        start_s     = 1'b1;
                        start_val_s = bus;
                        pend_v_d    = 1'b0;
                    end else if (pend_v_q) begin
                        start_s     = 1'b1;
                        start_val_s = pend_val_q;
                        pend_v_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (disp) begin
                    pend_val_d = bus;
                    pend_v_d   = 1'b1;
                end else begin
                    pend_v_d = pend_v_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef SIGNED_DISPLAY_EN
        start_neg_s = start_val_s[7];
`else
        start_neg_s = 1'b0;
`endif

        if (start_s) begin
            state_d    = CONV;
            shift_d    = {12'h000, mag_of(start_val_s)};
            iter_d     = 4'd0;
            neg_next_d = start_neg_s;
        end else begin
            neg_next_d = neg_next_q;
        end
    end

    // Display scan: refresh counter, digit select and registered seg/an codes.
    always_comb begin
        ref_cnt_d = ref_cnt_q + CW'(1);
        sel_d     = sel_q;
        if (ref_cnt_q == REF_MAX) begin
            ref_cnt_d = '0;
            sel_d     = sel_q + 2'd1;
        end else begin
            sel_d = sel_q;
        end

        an_d = ~(4'b0001 << sel_q);
        case (sel_q)
            2'd0: seg_d = seg_code(dig_o_q);
            2'd1: seg_d = ((dig_h_q == 4'd0) && (dig_t_q == 4'd0)) ? 7'h7F : seg_code(dig_t_q);
            2'd2: seg_d = (dig_h_q == 4'd0) ? 7'h7F : seg_code(dig_h_q);
            2'd3: seg_d = neg_q ? 7'h3F : 7'h7F;
            default: seg_d = 7'h7F;
        endcase

        busy_d = (state_d == CONV);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q    <= IDLE;
            shift_q    <= 20'h00000;
            iter_q     <= 4'd0;
            neg_next_q <= 1'b0;
            pend_val_q <= 8'h00;
            pend_v_q   <= 1'b0;
            dig_h_q    <= 4'd0;
            dig_t_q    <= 4'd0;
            dig_o_q    <= 4'd0;
            neg_q      <= 1'b0;
            ref_cnt_q  <= '0;
            sel_q      <= 2'd0;
            seg_q      <= 7'h7F;
            an_q       <= 4'hF;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            iter_q     <= iter_d;
            neg_next_q <= neg_next_d;
            pend_val_q <= pend_val_d;
            pend_v_q   <= pend_v_d;
            dig_h_q    <= dig_h_d;
            dig_t_q    <= dig_t_d;
            dig_o_q    <= dig_o_d;
            neg_q      <= neg_d;
            ref_cnt_q  <= ref_cnt_d;
            sel_q      <= sel_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
            busy_q     <= busy_d;
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign busy = busy_q;

endmodule

// File: doc/display_driver.md
# display_driver

Output-display stage downstream of the sequencer: consumes the sequencer's `disp` strobe and the shared 8-bit bus. When `disp` is sampled, it latches the bus, converts it to three BCD digits with a sequential shift-add-3 (double-dabble) engine, and drives a 4-digit, time-multiplexed, common-anode seven-segment display. It has a one-deep pending buffer, so back-to-back strobes are never stalled.

## Interface
- `REFRESH_DIV`, 1024: clock cycles each digit stays enabled; legal range ≥ 2.
- `clk` input 1: system clock, rising-edge.
- `res` input 1: asynchronous, active-low reset.
- `disp` input 1: display-load strobe from the sequencer; sampled on the rising edge of `clk`.
- `bus` input 8: shared data bus, sampled together with `disp`.
- `seg` output 7: segments `{g,f,e,d,c,b,a}`, active-low.
- `an` output 4: digit enables, active-low; `an[0]` is ones, `an[1]` tens, `an[2]` hundreds, `an[3]` sign.
- `busy` output 1: high while a conversion is in progress.

## Operation
- Registers:
  - `pend_val[7:0]` and `pend_v`: one-deep pending buffer.
  - `shift[19:0]`: 12-bit BCD field plus 8-bit binary field.
  - `iter[3:0]`: conversion iteration counter.
  - `dig_h`, `dig_t`, `dig_o[3:0]` and `neg`: committed display value.
  - `ref_cnt` and `sel[1:0]`: display scan.
- FSM states: IDLE, CONV.
  - IDLE with `disp`=1: load `shift` = {12'h000, magnitude(bus)}, capture sign into `neg_next`, set `iter`=0, go to CONV.
  - CONV, every cycle: for each BCD nibble ≥ 5, add 3; then shift the 20-bit word left by 1; increment `iter`.
  - CONV at the edge where `iter`=7: perform the final shift and commit BCD nibbles [19:8] to `dig_h`/`dig_t`/`dig_o` and `neg_next` to `neg`. Then:
    - if `pend_v`, start a new conversion from `pend_val` (stay in CONV) and clear `pend_v`;
    - else go to IDLE.
- `disp`=1 while in CONV: write `bus` into `pend_val` and set `pend_v`. A later strobe overwrites an earlier pending one (latest wins; intermediate values are dropped). If `disp` coincides with the commit edge, the strobe value goes straight into the new conversion and `pend_val` is unused.
- Digits displayed during CONV are the previously committed ones; there is no tearing.
- Leading-zero blanking:
  - hundreds blank when `dig_h`=0;
  - tens blank when `dig_h`=0 and `dig_t`=0;
  - ones always shown.
- Sign digit shows minus (`seg`=7'b0111111) when `neg`=1, else blank (7'h7F).
- Segment codes (hex, active-low `{g..a}`): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, blank=7F.
- Scan:
  - `ref_cnt` counts 0..REFRESH_DIV-1 and wraps.
  - At wrap, `sel` increments 0→1→2→3→0.
  - `an` = ~(4'b0001 << `sel`), and `seg` is the code for the selected digit. Both are registered.

## Timing
- Reset (async, `res`=0) takes effect immediately:
  - `seg`=7'h7F, `an`=4'hF, `busy`=0;
  - state IDLE, `pend_v`=0, digits 0, `neg`=0, `ref_cnt`=0, `sel`=0.
- First edge after `res` release: `an`=4'b1110, `seg`=7'h40 (shows "0").
- Conversion latency:
  - `disp` sampled at edge N; `busy`=1 after edge N.
  - New digits are committed at edge N+8. Registered `seg` reflects them from edge N+9 when that digit is selected.
  - `busy` falls after edge N+8 unless pending work exists. With back-to-back strobes it stays high continuously.
- `busy` is informational only: the sequencer never waits on it, and strobes are accepted in every cycle.
- Reset asserted mid-conversion aborts it, discards pending data and restores all reset values.

## Configuration
- `SIGNED_DISPLAY_EN` defined:
  - `bus` is two's complement. When `bus[7]`=1, magnitude = (~bus+1) in 8 bits, so 8'h80 gives 128, and `neg`=1.
  - Range shown: -128..127.
- `SIGNED_DISPLAY_EN` undefined:
  - magnitude = `bus`, `neg` is tied to 0 and the sign digit is always blank.
  - Range shown: 0..255.

## Test plan
- Reset → `seg`=7F, `an`=F, `busy`=0. Release, with REFRESH_DIV=4 → `an` cycles E,D,B,7 every 4 clocks and `seg` shows 40,7F,7F,7F.
- One `disp` pulse, `bus`=8'd255 (unsigned build) → `busy` high for 8 cycles. Digits `dig_h`/`dig_t`/`dig_o`=2/5/5 → `seg` 24,12,12 on hundreds/tens/ones.
- `disp` with `bus`=8'd7 → ones=78, tens and hundreds blank (7F), sign blank.
- `disp` with 12, then with 34 at N+2, then 56 at N+4 → display shows 12 after N+8. Then 56 after N+16; 34 never appears; `busy` continuous from N to N+16.
- Signed build: `bus`=8'hFF → sign=3F, ones=79 ("-1"); `bus`=8'h80 → "-128". Unsigned build: 8'hFF → "255".
- `res` pulled low at N+4 of a conversion of 99 → all outputs return to reset values immediately. After release, "0" is shown and `busy`=0.
